// File: rtl/crc_pkg.sv
// rtl/crc_pkg.sv - shared constants, bit-reflection helpers and FSM states for the CRC engine
package crc_pkg;

    localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_XOR_OUT = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_DONE = 2'd2
    } crc_state_t;

    function automatic logic [7:0] reflect8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = b[7-i];
        end
        return r;
    endfunction

    // Full-word reflection is just the byte order swapped with each byte reflected.
    function automatic logic [31:0] reflect32(input logic [31:0] w);
        return {reflect8(w[7:0]), reflect8(w[15:8]), reflect8(w[23:16]), reflect8(w[31:24])};
    endfunction

endpackage

// File: rtl/crc32_stream_if.sv
// rtl/crc32_stream_if.sv - framed beat input and held result output of the CRC engine
interface crc32_stream_if #(
    parameter int DATA_W = 32
) ();

    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_W-1:0]     s_data;
    logic [DATA_W/8-1:0]   s_keep;
    logic                  s_first;
    logic                  s_last;

    logic                  m_valid;
    logic                  m_ready;
    logic [31:0]           m_crc;
    logic                  m_match;

    modport master (
        output s_valid, s_data, s_keep, s_first, s_last, m_ready,
        input  s_ready, m_valid, m_crc, m_match
    );

    modport slave (
        input  s_valid, s_data, s_keep, s_first, s_last, m_ready,
        output s_ready, m_valid, m_crc, m_match
    );

endinterface

// File: rtl/crc32_byte_step.sv
// rtl/crc32_byte_step.sv - one byte of bit-serial CRC division, combinational
module crc32_byte_step
    import crc_pkg::*;
#(
    parameter logic [31:0] POLY    = CRC32_POLY,
    parameter bit          REFLECT = 1'b1
) (
    input  logic [31:0] crc_i,
    input  logic [7:0]  data_i,
    output logic [31:0] crc_o
);

    // A reflected register shifts right against the mirrored polynomial.
    localparam logic [31:0] POLY_R = reflect32(POLY);

    logic [31:0] c;

    always_comb begin
        c = crc_i;
        if (REFLECT) begin
            c = c ^ {24'd0, data_i};
            for (int b = 0; b < 8; b++) begin
                c = c[0] ? ((c >> 1) ^ POLY_R) : (c >> 1);
            end
        end else begin
            c = c ^ {data_i, 24'd0};
            for (int b = 0; b < 8; b++) begin
                c = c[31] ? ((c << 1) ^ POLY) : (c << 1);
            end
        end
        crc_o = c;
    end

endmodule

// File: rtl/crc32_stream.sv
// rtl/crc32_stream.sv - streaming framed CRC generator/checker with keep lanes and held result
module crc32_stream
    import crc_pkg::*;
#(
    parameter int          DATA_W  = 32,
    parameter logic [31:0] POLY    = CRC32_POLY,
    parameter logic [31:0] INIT    = CRC32_INIT,
    parameter logic [31:0] XOR_OUT = CRC32_XOR_OUT,
    parameter bit          REFLECT = 1'b1,
    parameter logic [31:0] RESIDUE = CRC32_RESIDUE
) (
    input  logic           clk,
    input  logic           rst_n,
    crc32_stream_if.slave  bus,
    output logic [15:0]    abort_cnt
);

    localparam int NB = DATA_W / 8;

    crc_state_t  state_q, state_d;
    logic [31:0] crc_q, crc_d;
    logic [31:0] m_crc_q, m_crc_d;
    logic        m_match_q, m_match_d;
    logic        m_valid_q, m_valid_d;
    logic [15:0] abort_q, abort_d;

    logic        s_ready;
    logic        accept;
    logic        seed;
    logic [31:0] seed_crc;
    logic [31:0] crc_next;

    assign s_ready  = (state_q != ST_DONE) || bus.m_ready;
    assign accept   = bus.s_valid && s_ready;
    // Any beat that opens a frame, or restarts one via s_first, ignores the running value.
    assign seed     = (state_q != ST_ACC) || bus.s_first;
    assign seed_crc = seed ? INIT : crc_q;

    for (genvar i = 0; i < NB; i++) begin : g_lane
        logic [31:0] crc_in;
        logic [31:0] crc_step;
        logic [31:0] crc_out;

        if (i == 0) begin : g_head
            assign crc_in = seed_crc;
        end else begin : g_link
            assign crc_in = g_lane[i-1].crc_out;
        end

        crc32_byte_step #(
            .POLY    (POLY),
            .REFLECT (REFLECT)
        ) u_step (
            .crc_i  (crc_in),
            .data_i (bus.s_data[8*i +: 8]),
            .crc_o  (crc_step)
        );

        assign crc_out = bus.s_keep[i] ? crc_step : crc_in;
    end

    assign crc_next = g_lane[NB-1].crc_out;

    always_comb begin
        state_d   = state_q;
        crc_d     = crc_q;
        m_crc_d   = m_crc_q;
        m_match_d = m_match_q;
        m_valid_d = m_valid_q;
        abort_d   = abort_q;

        if (accept) begin
            crc_d = crc_next;
            if ((state_q == ST_ACC) && bus.s_first && (abort_q != 16'hFFFF)) begin
                abort_d = abort_q + 16'd1;
            end
            if (bus.s_last) begin
                state_d   = ST_DONE;
                m_valid_d = 1'b1;
                m_crc_d   = crc_next ^ XOR_OUT;
                m_match_d = (crc_next == RESIDUE);
            end else begin
                state_d   = ST_ACC;
                m_valid_d = 1'b0;
            end
        end else if ((state_q == ST_DONE) && bus.m_ready) begin
            state_d   = ST_IDLE;
            m_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            crc_q     <= INIT;
            m_crc_q   <= 32'd0;
            m_match_q <= 1'b0;
            m_valid_q <= 1'b0;
            abort_q   <= 16'd0;
        end else begin
            state_q   <= state_d;
            crc_q     <= crc_d;
            m_crc_q   <= m_crc_d;
            m_match_q <= m_match_d;
            m_valid_q <= m_valid_d;
            abort_q   <= abort_d;
        end
    end

    assign bus.s_ready = s_ready;
    assign bus.m_valid = m_valid_q;
    assign bus.m_crc   = m_crc_q;
    assign bus.m_match = m_match_q;
    assign abort_cnt   = abort_q;

endmodule

// File: tb/tb_crc32_stream.sv
// tb/tb_crc32_stream.sv - self-checking bench for crc32_stream (reflected and MSB-first instances)
module tb_crc32_stream;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] abort_cnt;
    logic [15:0] abort_cnt_n;

    always #5 clk = ~clk;

    crc32_stream_if #(.DATA_W(32)) bus ();
    crc32_stream_if #(.DATA_W(32)) bus_n ();

    assign bus_n.s_valid = bus.s_valid;
    assign bus_n.s_data  = bus.s_data;
    assign bus_n.s_keep  = bus.s_keep;
    assign bus_n.s_first = bus.s_first;
    assign bus_n.s_last  = bus.s_last;
    assign bus_n.m_ready = bus.m_ready;

    crc32_stream #(.DATA_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .abort_cnt (abort_cnt)
    );

    crc32_stream #(.DATA_W(32), .REFLECT(1'b0)) dut_n (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus_n),
        .abort_cnt (abort_cnt_n)
    );

    typedef struct {
        logic [31:0] crc;
        logic        match;
        logic [31:0] crc_n;
        logic        match_n;
        logic        valid_n;
    } res_t;

    typedef struct {
        logic [3:0][31:0] beats;
        int               nb;
        logic [3:0]       keep_last;
        logic [31:0]      crc;
        logic             match;
    } vec_t;

    res_t        exp_q[$];
    res_t        obs_q[$];
    logic [7:0]  cur_q[$];
    bit          in_frame;
    bit          rand_ready;
    logic [15:0] exp_abort;
    int          checks = 0;
    int          errors = 0;
    vec_t        tbl[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rev32(input logic [31:0] x);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = x[31-i];
        return r;
    endfunction

    // Plain MSB-first polynomial division; reflected mode is the mirror image of it.
    function automatic logic [31:0] model_raw(input logic [7:0] q[$], input bit refl);
        logic [31:0] r;
        logic        din;
        logic        fb;
        r = refl ? rev32(32'hFFFFFFFF) : 32'hFFFFFFFF;
        foreach (q[j]) begin
            for (int k = 0; k < 8; k++) begin
                din = refl ? q[j][k] : q[j][7-k];
                fb  = r[31] ^ din;
                r   = {r[30:0], 1'b0};
                if (fb) r = r ^ 32'h04C11DB7;
            end
        end
        return refl ? rev32(r) : r;
    endfunction

    task automatic model_beat(input logic [31:0] d, input logic [3:0] k, input logic f, input logic l);
        res_t        e;
        logic [31:0] rr;
        logic [31:0] rn;
        if (!in_frame) begin
            cur_q.delete();
        end else if (f) begin
            cur_q.delete();
            if (exp_abort != 16'hFFFF) exp_abort++;
        end
        for (int i = 0; i < 4; i++) if (k[i]) cur_q.push_back(d[8*i +: 8]);
        if (l) begin
            rr = model_raw(cur_q, 1'b1);
            rn = model_raw(cur_q, 1'b0);
            e.crc     = rr ^ 32'hFFFFFFFF;
            e.match   = (rr == 32'hDEBB20E3);
            e.crc_n   = rn ^ 32'hFFFFFFFF;
            e.match_n = (rn == 32'hDEBB20E3);
            e.valid_n = 1'b1;
            exp_q.push_back(e);
            in_frame = 1'b0;
        end else begin
            in_frame = 1'b1;
        end
    endtask

    // Entered and left at posedge+1; the beat is taken on the edge after s_ready is seen.
    task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic f, input logic l);
        int n;
        n = 0;
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_keep  = k;
        bus.s_first = f;
        bus.s_last  = l;
        @(negedge clk);
        while (!bus.s_ready && n < 200) begin
            @(posedge clk);
            #1;
            if (rand_ready) bus.m_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            n++;
        end
        if (!bus.s_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got s_ready=0 expected beat accepted within 200 cycles");
        end else begin
            model_beat(d, k, f, l);
        end
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
    endtask

    task automatic send_123456789(input logic mr);
        bus.m_ready = mr;
        send_beat(32'h34333231, 4'hF, 1'b1, 1'b0);
        send_beat(32'h38373635, 4'hF, 1'b0, 1'b0);
        send_beat(32'h00000039, 4'h1, 1'b0, 1'b1);
    endtask

    task automatic drain();
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b1;
        for (int n = 0; n < 50 && obs_q.size() < exp_q.size(); n++) begin
            @(posedge clk);
            #1;
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic compare_sb(input string tag);
        res_t o;
        res_t e;
        check({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            check({tag, "_crc"},     o.crc,           e.crc);
            check({tag, "_match"},   32'(o.match),   32'(e.match));
            check({tag, "_crc_n"},   o.crc_n,         e.crc_n);
            check({tag, "_match_n"}, 32'(o.match_n), 32'(e.match_n));
            check({tag, "_valid_n"}, 32'(o.valid_n), 32'(e.valid_n));
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    always @(negedge clk) begin : monitor
        res_t r;
        if (rst_n === 1'b1 && bus.m_valid === 1'b1 && bus.m_ready === 1'b1) begin
            r.crc     = bus.m_crc;
            r.match   = bus.m_match;
            r.crc_n   = bus_n.m_crc;
            r.match_n = bus_n.m_match;
            r.valid_n = bus_n.m_valid;
            obs_q.push_back(r);
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin : main
        logic [31:0] d;
        logic [4:0]  t;
        logic [3:0]  k;
        logic        f;
        int          nb;

        tbl[0].beats = {32'h0, 32'h00000039, 32'h38373635, 32'h34333231};
        tbl[0].nb = 3; tbl[0].keep_last = 4'b0001; tbl[0].crc = 32'hCBF43926; tbl[0].match = 1'b0;
        tbl[1].beats = {32'h000000CB, 32'hF4392639, 32'h38373635, 32'h34333231};
        tbl[1].nb = 4; tbl[1].keep_last = 4'b0001; tbl[1].crc = 32'h2144DF1C; tbl[1].match = 1'b1;
        tbl[2].beats = {32'h0, 32'h0, 32'h0, 32'hA5A5A5A5};
        tbl[2].nb = 1; tbl[2].keep_last = 4'b0000; tbl[2].crc = 32'h00000000; tbl[2].match = 1'b0;
        tbl[3].beats = {32'h0, 32'h0, 32'h0, 32'hDEADBE61};
        tbl[3].nb = 1; tbl[3].keep_last = 4'b0001; tbl[3].crc = 32'hE8B7BE43; tbl[3].match = 1'b0;
        tbl[4].beats = {32'h0, 32'h0, 32'h0, 32'hFF636261};
        tbl[4].nb = 1; tbl[4].keep_last = 4'b0111; tbl[4].crc = 32'h352441C2; tbl[4].match = 1'b0;

        in_frame    = 1'b0;
        rand_ready  = 1'b0;
        exp_abort   = 16'd0;
        rst_n       = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = 32'd0;
        bus.s_keep  = 4'd0;
        bus.s_first = 1'b0;
        bus.s_last  = 1'b0;
        bus.m_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_m_valid", 32'(bus.m_valid), 32'd0);
        check("rst_m_crc",   bus.m_crc,        32'd0);
        check("rst_m_match", 32'(bus.m_match), 32'd0);
        check("rst_abort",   32'(abort_cnt),   32'd0);
        check("rst_s_ready", 32'(bus.s_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int v = 0; v < 5; v++) begin
            bus.m_ready = 1'b1;
            for (int b = 0; b < tbl[v].nb; b++) begin
                send_beat(tbl[v].beats[b], (b == tbl[v].nb - 1) ? tbl[v].keep_last : 4'hF,
                          1'(b == 0), 1'(b == tbl[v].nb - 1));
            end
            check($sformatf("vec%0d_m_valid", v), 32'(bus.m_valid), 32'd1);
            check($sformatf("vec%0d_m_crc", v),   bus.m_crc,        tbl[v].crc);
            check($sformatf("vec%0d_m_match", v), 32'(bus.m_match), 32'(tbl[v].match));
            if (v == 0) check("msb_first_m_crc", bus_n.m_crc, 32'hFC891918);
        end
        drain();
        compare_sb("table");

        send_123456789(1'b0);
        check("bp_m_valid", 32'(bus.m_valid), 32'd1);
        bus.s_valid = 1'b1;
        bus.s_data  = 32'h34333231;
        bus.s_keep  = 4'hF;
        bus.s_first = 1'b1;
        bus.s_last  = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("bp_s_ready_c%0d", c), 32'(bus.s_ready), 32'd0);
            check($sformatf("bp_m_crc_c%0d", c),   bus.m_crc,        32'hCBF43926);
            @(posedge clk);
            #1;
        end
        bus.m_ready = 1'b1;
        @(negedge clk);
        check("bp_release_s_ready", 32'(bus.s_ready), 32'd1);
        if (bus.s_ready) model_beat(32'h34333231, 4'hF, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        check("bp_release_m_valid", 32'(bus.m_valid), 32'd0);
        send_beat(32'h38373635, 4'hF, 1'b0, 1'b0);
        send_beat(32'h00000039, 4'h1, 1'b0, 1'b1);
        check("bp_second_m_crc", bus.m_crc, 32'hCBF43926);
        drain();
        compare_sb("backpressure");

        bus.m_ready = 1'b1;
        send_beat($urandom, 4'hF, 1'b1, 1'b0);
        send_beat($urandom, 4'hF, 1'b0, 1'b0);
        send_123456789(1'b1);
        check("abort_m_crc", bus.m_crc,      32'hCBF43926);
        check("abort_cnt",   32'(abort_cnt), 32'd1);
        for (int i = 0; i < 3; i++) begin
            t = (5'd1 << $urandom_range(0, 4)) - 5'd1;
            send_beat($urandom, t[3:0], 1'b1, 1'b1);
            check($sformatf("b2b_m_valid_%0d", i), 32'(bus.m_valid), 32'd1);
        end
        drain();
        compare_sb("abort_b2b");
        check("abort_cnt_model", 32'(abort_cnt), 32'(exp_abort));

        send_beat(32'h34333231, 4'hF, 1'b1, 1'b0);
        send_beat(32'h38373635, 4'hF, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_m_valid", 32'(bus.m_valid), 32'd0);
        check("mid_rst_m_crc",   bus.m_crc,        32'd0);
        check("mid_rst_m_match", 32'(bus.m_match), 32'd0);
        check("mid_rst_abort",   32'(abort_cnt),   32'd0);
        in_frame  = 1'b0;
        exp_abort = 16'd0;
        cur_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_123456789(1'b1);
        check("post_rst_m_crc", bus.m_crc, 32'hCBF43926);
        drain();
        compare_sb("reset");

        rand_ready = 1'b1;
        for (int fr = 0; fr < 300; fr++) begin
            nb = $urandom_range(1, 5);
            for (int b = 0; b < nb; b++) begin
                if ($urandom_range(0, 3) == 0) begin
                    bus.s_valid = 1'b0;
                    bus.m_ready = 1'($urandom_range(0, 1));
                    @(posedge clk);
                    #1;
                end
                bus.m_ready = 1'($urandom_range(0, 1));
                d = $urandom;
                f = (b == 0) ? 1'($urandom_range(0, 9) != 0) : 1'($urandom_range(0, 19) == 0);
                if (b == nb - 1) begin
                    t = (5'd1 << $urandom_range(0, 4)) - 5'd1;
                    k = t[3:0];
                end else begin
                    k = 4'hF;
                end
                send_beat(d, k, f, 1'(b == nb - 1));
            end
        end
        rand_ready = 1'b0;
        drain();
        compare_sb("random");
        check("rand_abort_cnt",   32'(abort_cnt),   32'(exp_abort));
        check("rand_abort_cnt_n", 32'(abort_cnt_n), 32'(exp_abort));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
